// File: rtl/alu_scoreboard_if.sv
// Handshake and status bundle between the ALU stimulus/DUT side and the scoreboard.
// master = stimulus/checker driver, slave = scoreboard.
interface alu_scoreboard_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             exp_valid;
  logic             exp_ready;
  logic [2:0]       exp_op;
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  logic             act_valid;
  logic             act_ready;
  logic [WIDTH-1:0] act_result;
  logic             match_valid;
  logic             match_ok;
  logic [CNT_W-1:0] check_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_err;
  logic [WIDTH-1:0] err_exp;
  logic [WIDTH-1:0] err_act;
  logic [LVL_W-1:0] level;

  modport master (
    output exp_valid, exp_op, exp_a, exp_b, act_valid, act_result,
    input  exp_ready, act_ready, match_valid, match_ok, check_cnt,
           mismatch_cnt, first_err, err_exp, err_act, level
  );

  modport slave (
    input  exp_valid, exp_op, exp_a, exp_b, act_valid, act_result,
    output exp_ready, act_ready, match_valid, match_ok, check_cnt,
           mismatch_cnt, first_err, err_exp, err_act, level
  );
endinterface

// File: rtl/alu_scoreboard.sv
// ALU scoreboard: computes golden results at push, queues them, compares against
// DUT results at pop and keeps saturating statistics plus a first-mismatch capture.
module alu_scoreboard #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  alu_scoreboard_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             exp_ready, act_ready, push, pop, mismatch;
  logic [WIDTH-1:0] golden, head;
  logic             match_valid, match_ok, first_err;
  logic [CNT_W-1:0] check_cnt, mismatch_cnt;
  logic [WIDTH-1:0] err_exp, err_act;

  assign exp_ready = (level != LVL_W'(DEPTH));
  assign act_ready = (level != '0);
  assign push      = sb.exp_valid && exp_ready;
  assign pop       = sb.act_valid && act_ready;
  assign head      = mem[rd_ptr];
  assign mismatch  = (head != sb.act_result);

  always_comb begin
    golden = '0;
    case (sb.exp_op)
      OP_AND:  golden = sb.exp_a & sb.exp_b;
      OP_OR:   golden = sb.exp_a | sb.exp_b;
      OP_XOR:  golden = sb.exp_a ^ sb.exp_b;
      OP_ADD:  golden = sb.exp_a + sb.exp_b;
      OP_SUB:  golden = sb.exp_a - sb.exp_b;
      OP_NOT:  golden = ~sb.exp_a;
      OP_SHL:  golden = {sb.exp_a[WIDTH-2:0], 1'b0};
      OP_SHR:  golden = sb.exp_a >> 1;
      default: golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= golden;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Compare result is registered at the pop edge; clear overrides the stat update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid  <= 1'b0;
      match_ok     <= 1'b0;
      check_cnt    <= '0;
      mismatch_cnt <= '0;
      first_err    <= 1'b0;
      err_exp      <= '0;
      err_act      <= '0;
    end else begin
      match_valid <= pop;
      if (pop) match_ok <= !mismatch;
      if (clear) begin
        check_cnt    <= '0;
        mismatch_cnt <= '0;
        first_err    <= 1'b0;
        err_exp      <= '0;
        err_act      <= '0;
      end else if (pop) begin
        if (check_cnt != '1) check_cnt <= check_cnt + CNT_W'(1);
        if (mismatch) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (!first_err) begin
            first_err <= 1'b1;
            err_exp   <= head;
            err_act   <= sb.act_result;
          end
        end
      end
    end
  end

  assign sb.exp_ready    = exp_ready;
  assign sb.act_ready    = act_ready;
  assign sb.level        = level;
  assign sb.match_valid  = match_valid;
  assign sb.match_ok     = match_ok;
  assign sb.check_cnt    = check_cnt;
  assign sb.mismatch_cnt = mismatch_cnt;
  assign sb.first_err    = first_err;
  assign sb.err_exp      = err_exp;
  assign sb.err_act      = err_act;
endmodule

// File: tb/tb_alu_scoreboard.sv
// Randomized and directed bench for alu_scoreboard against a queue-based reference model.
module tb_alu_scoreboard;
  localparam int W     = 4;
  localparam int D     = 4;
  localparam int CW    = 8;
  localparam int MASK  = (1 << W) - 1;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  alu_scoreboard_if #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) bus ();

  alu_scoreboard #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .sb    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int q[$];
  int m_check, m_mis, m_eexp, m_eact;
  bit m_first, m_ok, m_mv;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int golden(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return (a + b) & MASK;
      4: return (a - b) & MASK;
      5: return MASK - a;
      6: return (a * 2) & MASK;
      default: return a / 2;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    m_check = 0; m_mis = 0; m_eexp = 0; m_eact = 0;
    m_first = 0; m_ok = 0; m_mv = 0;
  endfunction

  task automatic compare_all(input string ph);
    check({ph, ":level"},        int'(bus.level),        q.size());
    check({ph, ":match_valid"},  int'(bus.match_valid),  int'(m_mv));
    check({ph, ":match_ok"},     int'(bus.match_ok),     int'(m_ok));
    check({ph, ":check_cnt"},    int'(bus.check_cnt),    m_check);
    check({ph, ":mismatch_cnt"}, int'(bus.mismatch_cnt), m_mis);
    check({ph, ":first_err"},    int'(bus.first_err),    int'(m_first));
    check({ph, ":err_exp"},      int'(bus.err_exp),      m_eexp);
    check({ph, ":err_act"},      int'(bus.err_act),      m_eact);
  endtask

  // Called at posedge+1; drives one cycle, updates the model, checks at the next posedge+1.
  task automatic cycle(input string ph, input bit ev, input int op, input int a, input int b,
                       input bit av, input int ar, input bit clr);
    bit do_push, do_pop;
    int hd;
    bus.exp_valid  = ev;
    bus.exp_op     = 3'(op);
    bus.exp_a      = W'(a);
    bus.exp_b      = W'(b);
    bus.act_valid  = av;
    bus.act_result = W'(ar);
    clear          = clr;
    #1;
    check({ph, ":exp_ready"}, int'(bus.exp_ready), int'(q.size() != D));
    check({ph, ":act_ready"}, int'(bus.act_ready), int'(q.size() != 0));
    do_push = ev && (q.size() != D);
    do_pop  = av && (q.size() != 0);
    @(posedge clk);
    #1;
    m_mv = do_pop;
    if (do_pop) begin
      hd   = q.pop_front();
      m_ok = (hd == ar);
    end
    if (clr) begin
      m_check = 0; m_mis = 0; m_first = 0; m_eexp = 0; m_eact = 0;
    end else if (do_pop) begin
      if (m_check < MAXC) m_check++;
      if (hd != ar) begin
        if (m_mis < MAXC) m_mis++;
        if (!m_first) begin
          m_first = 1; m_eexp = hd; m_eact = ar;
        end
      end
    end
    if (do_push) q.push_back(golden(op, a, b));
    compare_all(ph);
  endtask

  task automatic idle(input string ph);
    cycle(ph, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int op, a, b, ar;
    bit ev, av, clr;

    rst_n = 1'b0;
    clear = 1'b0;
    bus.exp_valid = 1'b0; bus.exp_op = '0; bus.exp_a = '0; bus.exp_b = '0;
    bus.act_valid = 1'b0; bus.act_result = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    check("reset:exp_ready", int'(bus.exp_ready), 1);
    check("reset:act_ready", int'(bus.act_ready), 0);
    rst_n = 1'b1;

    // XOR match
    cycle("xor_push", 1, 2, 4'b1100, 4'b1001, 0, 0, 0);
    cycle("xor_pop",  0, 0, 0, 0, 1, 4'b0101, 0);
    idle("xor_after");

    // ADD wrap mismatch, then a second mismatch must not move the capture
    cycle("add_push", 1, 3, 4'b1111, 4'b0001, 0, 0, 0);
    cycle("add_pop",  0, 0, 0, 0, 1, 4'b0001, 0);
    check("add:err_exp_const", int'(bus.err_exp), 0);
    check("add:err_act_const", int'(bus.err_act), 1);
    cycle("mis2_push", 1, 0, 4'b1111, 4'b1111, 0, 0, 0);
    cycle("mis2_pop",  0, 0, 0, 0, 1, 4'b0011, 0);

    // Fill to full, blocked 5th push, drain in order
    for (int i = 0; i < 5; i++) cycle("fill", 1, 3, i + 1, 0, 0, 0, 0);
    check("full:level_const", int'(bus.level), D);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 0, 0, 1, i + 1, 0);
    idle("drain_idle");

    // Full with simultaneous pop: push still blocked
    for (int i = 0; i < 4; i++) cycle("refill", 1, 7, 2 * i + 8, 0, 0, 0, 0);
    cycle("full_pushpop", 1, 1, 3, 5, 1, q[0], 0);
    while (q.size() > 0) cycle("flush", 0, 0, 0, 0, 1, q[0], 0);

    // Level 2 with 6 concurrent push/pop cycles
    cycle("l2_a", 1, 6, 4'b1011, 0, 0, 0, 0);
    cycle("l2_b", 1, 4, 4'b0010, 4'b0101, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      cycle("pushpop", 1, i, $urandom_range(0, MASK), $urandom_range(0, MASK), 1, q[0], 0);
    while (q.size() > 0) cycle("flush2", 0, 0, 0, 0, 1, q[0], 0);

    // act_valid while empty, then clear, then clear on a pop edge
    for (int i = 0; i < 3; i++) cycle("empty_act", 0, 0, 0, 0, 1, 9, 0);
    cycle("pre_clr_push", 1, 5, 3, 0, 0, 0, 0);
    cycle("clear", 0, 0, 0, 0, 0, 0, 1);
    cycle("clr_pop", 0, 0, 0, 0, 1, 7, 1);
    idle("clr_after");

    // Saturation: continuous mismatching traffic
    for (int i = 0; i < 280; i++) begin
      ar = (q.size() > 0) ? ((q[0] + 1) & MASK) : 0;
      cycle("sat", 1, $urandom_range(0, 7), $urandom_range(0, MASK), $urandom_range(0, MASK), 1, ar, 0);
    end
    check("sat:check_cnt_max", int'(bus.check_cnt), MAXC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ev  = ($urandom % 4) != 0;
      av  = ($urandom % 3) != 0;
      clr = ($urandom % 60) == 0;
      op  = $urandom_range(0, 7);
      a   = $urandom_range(0, MASK);
      b   = $urandom_range(0, MASK);
      ar  = (q.size() > 0 && ($urandom % 4) != 0) ? q[0] : $urandom_range(0, MASK);
      cycle("rand", ev, op, a, b, av, ar, clr);
    end

    // Reset with 3 queued entries and a pop in flight
    while (q.size() > 0) cycle("pre_rst_flush", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("pre_rst_fill", 1, 1, i, 8, 0, 0, 0);
    bus.exp_valid = 1'b0;
    bus.act_valid = 1'b1;
    bus.act_result = '0;
    clear = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst:act_ready", int'(bus.act_ready), 0);
    check("async_rst:exp_ready", int'(bus.exp_ready), 1);
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    bus.act_valid = 1'b0;
    rst_n = 1'b1;
    idle("post_rst");
    cycle("post_rst_push", 1, 2, 5, 3, 0, 0, 0);
    cycle("post_rst_pop",  0, 0, 0, 0, 1, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_scoreboard.md
Name: alu_scoreboard

Overview:
Checking end of the integer ALU verification path.
- The stimulus side pushes each operation (op, A, B); the block computes the golden result and queues it in a small FIFO.
- The DUT side later presents its actual result; the block pops the oldest expected value, compares, and keeps pass/fail statistics plus a capture of the first mismatch.
- Synthesisable, so the same check runs in simulation and on an FPGA self-test harness.

Parameters:
WIDTH, 4, operand/result width in bits
DEPTH, 4, FIFO entries; power of two, >=2
CNT_W, 8, width of check and mismatch counters

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of counters and sticky error state (FIFO untouched)
exp_valid  input  1  stimulus entry valid
exp_ready  output  1  FIFO can accept an entry
exp_op  input  3  operation code
exp_a  input  WIDTH  operand A
exp_b  input  WIDTH  operand B
act_valid  input  1  DUT result valid
act_ready  output  1  an expected entry is available
act_result  input  WIDTH  DUT result
match_valid  output  1  one-cycle pulse: a comparison completed
match_ok  output  1  result of that comparison (1 = equal)
check_cnt  output  CNT_W  comparisons performed, saturating
mismatch_cnt  output  CNT_W  mismatches, saturating
first_err  output  1  sticky: at least one mismatch since reset/clear
err_exp  output  WIDTH  expected value of first mismatch
err_act  output  WIDTH  actual value of first mismatch
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FIFO empty, pointers 0, level=0, match_valid=0, match_ok=0, counters=0, first_err=0, err_exp=0, err_act=0. exp_ready=1 and act_ready=0 follow combinationally.
- Golden result is computed at push; only the WIDTH-bit result is stored.
  - 000 A&B
  - 001 A|B
  - 010 A^B
  - 011 A+B mod 2^WIDTH
  - 100 A-B mod 2^WIDTH
  - 101 ~A
  - 110 A<<1, zero fill, MSB dropped
  - 111 A>>1 logical
- exp_ready = (level != DEPTH). Push occurs when exp_valid && exp_ready.
- act_ready = (level != 0). Pop occurs when act_valid && act_ready.
- No bypass: an entry pushed in cycle N is poppable from cycle N+1.
- Simultaneous push and pop: both occur; level unchanged; pointers each advance and wrap modulo DEPTH.
- Full: push is blocked even if a pop occurs in the same cycle, because exp_ready depends on the current level only.
- Empty: act_valid is ignored with no side effect.
- Comparison latency is 1 cycle. The cycle after a pop:
  - match_valid=1 and match_ok = (head == act_result).
  - check_cnt +1 and, if unequal, mismatch_cnt +1; both saturate at 2^CNT_W-1.
  - On a mismatch with first_err=0: err_exp/err_act capture head/act_result and first_err is set. Later mismatches do not overwrite the capture.
- match_valid is low in every cycle not following a pop; match_ok holds its last value.
- clear=1: counters, first_err, err_exp and err_act go to 0 next edge; the FIFO is unaffected.
- clear coinciding with a pop's update cycle: clear wins; the counters read 0 and the pending compare is not counted. match_valid/match_ok still pulse normally.
- Reset mid-operation: all queued entries are discarded immediately; any in-flight compare produces no match_valid.

Test Plan:
- Push op=010 A=1100 B=1001, then act_result=0101 -> match_valid one cycle after pop, match_ok=1, check_cnt=1, mismatch_cnt=0.
- Push op=011 A=1111 B=0001, then act_result=0001 -> expected 0000, match_ok=0, first_err=1, err_exp=0000, err_act=0001; a second mismatch leaves the capture unchanged.
- Push 4 entries with no pops -> level=4, exp_ready=0, 5th push ignored; pop 4 in order -> FIFO order preserved, level=0, act_ready=0.
- Level=2, push and pop in the same cycle for 6 cycles -> level stays 2, pointers wrap, all 6 compares correct.
- act_valid=1 while empty -> act_ready=0, no match_valid, counters unchanged; then assert clear after mismatches -> counters and first_err return to 0, level unchanged.
- Drop rst_n with 3 entries queued and a pop in flight -> level=0 at once, no match_valid, all outputs at reset values.
